// File: rtl/max_pool2x2_pkg.sv
// rtl/max_pool2x2_pkg.sv - shared CNN constants and signed-max helper
package max_pool2x2_pkg;

  localparam int POOL_WIN       = 2;
  localparam int DEFAULT_IN_D_W = 32;
  localparam int MAX_SAMPLE_W   = 64;

  typedef logic signed [MAX_SAMPLE_W-1:0] wide_sample_t;

  function automatic wide_sample_t smax(input wide_sample_t a, input wide_sample_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - horizontal-max line buffer, one write and one read port
module pool_line_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool2x2.sv
// rtl/max_pool2x2.sv - streaming 2x2 stride-2 signed max pooling
module max_pool2x2
  import max_pool2x2_pkg::*;
#(
  parameter int In_d_W = DEFAULT_IN_D_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [In_d_W-1:0] A,
  output logic signed [In_d_W-1:0] Y,
  output logic                     valid,
  output logic                     frame_done
);

  localparam int HALF_W = IMG_W / POOL_WIN;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [In_d_W-1:0] pair_q, pair_d;
  logic signed [In_d_W-1:0] y_q, y_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;

  logic                     odd_col, odd_row, last_col, last_row;
  logic signed [In_d_W-1:0] hmax, vmax, lb_rd;
  logic [AW-1:0]            lb_addr;
  logic                     lb_wr;

  assign odd_col  = col_q[0];
  assign odd_row  = row_q[0];
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));
  assign lb_addr  = AW'(col_q >> 1);
  assign lb_wr    = en && odd_col && !odd_row;

  // Compare at the package's wide width, then pick the native-width operand.
  assign hmax = (smax(wide_sample_t'(pair_q), wide_sample_t'(A)) == wide_sample_t'(pair_q))
              ? pair_q : A;
  assign vmax = (smax(wide_sample_t'(hmax), wide_sample_t'(lb_rd)) == wide_sample_t'(hmax))
              ? hmax : lb_rd;

  pool_line_buf #(
    .W     (In_d_W),
    .DEPTH (HALF_W),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr),
    .wr_addr (lb_addr),
    .wr_data (hmax),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    y_d     = y_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (en) begin
      if (!odd_col) pair_d = A;
      if (odd_col && odd_row) begin
        y_d     = vmax;
        valid_d = 1'b1;
        done_d  = last_col && last_row;
      end
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign Y          = y_q;
  assign valid      = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_max_pool2x2.sv
// tb/tb_max_pool2x2.sv - self-checking bench for max_pool2x2 on a 4x4 map
module tb_max_pool2x2;

  localparam int W  = 32;
  localparam int IW = 4;
  localparam int IH = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en  = 1'b0;
  logic signed [W-1:0] A   = '0;
  logic signed [W-1:0] Y;
  logic                valid;
  logic                frame_done;

  always #5 clk = ~clk;

  max_pool2x2 #(.In_d_W(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .A          (A),
    .Y          (Y),
    .valid      (valid),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whole-frame image plus bench-side raster position.
  int img [IH][IW];
  int mr = 0, mc = 0;
  int exp_y = 0;
  bit exp_valid = 1'b0, exp_fd = 1'b0;

  int got [$];
  int exp_list [$];
  int fd_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(negedge clk) begin
    chk("valid", valid, exp_valid);
    chk("frame_done", frame_done, exp_fd);
    chk("Y", Y, exp_y);
    if (valid) got.push_back(Y);
    if (frame_done) fd_cnt++;
  end

  task automatic send(input int v);
    @(negedge clk);
    #1;
    en = 1'b1;
    A  = v;
    img[mr][mc] = v;
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      exp_y     = max2(max2(img[mr-1][mc-1], img[mr-1][mc]), max2(img[mr][mc-1], v));
      exp_valid = 1'b1;
      exp_fd    = (mr == IH - 1) && (mc == IW - 1);
    end else begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
    end
    if (mc == IW - 1) begin
      mc = 0;
      mr = (mr == IH - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      en        = 1'b0;
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b0;
    mr = 0; mc = 0;
    exp_y = 0; exp_valid = 1'b0; exp_fd = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_outputs(input string name, input int fd_exp);
    chk({name, " count"}, got.size(), exp_list.size());
    for (int i = 0; i < exp_list.size() && i < got.size(); i++)
      chk($sformatf("%s out%0d", name, i), got[i], exp_list[i]);
    chk({name, " frame_done pulses"}, fd_cnt, fd_exp);
    got.delete();
    fd_cnt = 0;
  endtask

  initial begin
    #1;
    chk("reset Y", Y, 0);
    chk("reset valid", valid, 0);
    chk("reset frame_done", frame_done, 0);
    do_reset();

    for (int i = 0; i < 16; i++) send(i);
    idle(3);
    exp_list = '{5, 7, 13, 15};
    check_outputs("ramp", 1);

    begin
      int sv [16];
      sv = '{-3, -8, 4, 1, -5, -1, 2, 0, 10, -20, -7, -7, -30, -40, -7, -6};
      for (int i = 0; i < 16; i++) send(sv[i]);
    end
    idle(3);
    exp_list = '{-1, 4, 10, -6};
    check_outputs("signed", 1);

    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 2));
      send(i);
    end
    idle(3);
    exp_list = '{5, 7, 13, 15};
    check_outputs("gaps", 1);

    for (int i = 0; i < 32; i++) send(i);
    idle(3);
    exp_list = '{5, 7, 13, 15, 21, 23, 29, 31};
    check_outputs("back2back", 2);

    for (int i = 0; i < 6; i++) send(100 + i);
    idle(1);
    do_reset();
    got.delete();
    fd_cnt = 0;
    for (int i = 0; i < 16; i++) send(i);
    idle(3);
    exp_list = '{5, 7, 13, 15};
    check_outputs("midreset", 1);

    for (int i = 0; i < 16; i++) send(42);
    idle(3);
    exp_list = '{42, 42, 42, 42};
    check_outputs("equal", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
